// File: rtl/bpred_unit.sv
// rtl/bpred_unit.sv - direct-mapped BTB with 2-bit counters; BPRED_STATS_EN enables statistics counters
module bpred_unit #(
    parameter int BTB_ENTRIES = 8
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
);
    typedef logic [1:0] bpred_t;

    localparam int IW = $clog2(BTB_ENTRIES);
    localparam int TW = 30 - IW;

    logic          valid_q  [BTB_ENTRIES];
    logic          valid_d  [BTB_ENTRIES];
    logic [TW-1:0] tag_q    [BTB_ENTRIES];
    logic [TW-1:0] tag_d    [BTB_ENTRIES];
    logic [31:0]   target_q [BTB_ENTRIES];
    logic [31:0]   target_d [BTB_ENTRIES];
    bpred_t        ctr_q    [BTB_ENTRIES];
    bpred_t        ctr_d    [BTB_ENTRIES];

    logic [IW-1:0] if_idx;
    logic [TW-1:0] if_tag;
    logic [IW-1:0] upd_idx;
    logic [TW-1:0] upd_tag;
    logic          if_hit;
    logic          upd_hit;

    assign if_idx  = if_pc[IW+1:2];
    assign if_tag  = if_pc[31:IW+2];
    assign upd_idx = upd_pc[IW+1:2];
    assign upd_tag = upd_pc[31:IW+2];

    // Lookup reads registered state only, so a same-cycle update is never bypassed.
    assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign pred_taken  = if_hit && ctr_q[if_idx][1];
    assign pred_target = pred_taken ? target_q[if_idx] : 32'h0;

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (upd_en) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    target_d[upd_idx] = upd_target;
                    if (ctr_q[upd_idx] != 2'b11) begin
                        ctr_d[upd_idx] = ctr_q[upd_idx] + 2'b01;
                    end
                end else if (ctr_q[upd_idx] != 2'b00) begin
                    ctr_d[upd_idx] = ctr_q[upd_idx] - 2'b01;
                end
            end else if (upd_taken) begin
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = upd_target;
                ctr_d[upd_idx]    = 2'b10;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'h0;
                ctr_q[i]    <= 2'b00;
            end
        end else begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i]  <= valid_d[i];
                tag_q[i]    <= tag_d[i];
                target_q[i] <= target_d[i];
                ctr_q[i]    <= ctr_d[i];
            end
        end
    end

`ifdef BPRED_STATS_EN
    logic [31:0] br_count_q;
    logic [31:0] br_count_d;
    logic [31:0] mispred_count_q;
    logic [31:0] mispred_count_d;

    always_comb begin
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;
        if (upd_en) begin
            br_count_d = br_count_q + 32'd1;
            if (upd_pred_taken != upd_taken) begin
                mispred_count_d = mispred_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            br_count_q      <= 32'h0;
            mispred_count_q <= 32'h0;
        end else begin
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;
`else
    logic [4:0] unused_bits;
    assign unused_bits   = {upd_pred_taken, if_pc[1:0], upd_pc[1:0]};
    assign br_count      = 32'h0;
    assign mispred_count = 32'h0;
`endif

`ifdef BPRED_STATS_EN
    logic [3:0] unused_pc_bits;
    assign unused_pc_bits = {if_pc[1:0], upd_pc[1:0]};
`endif

endmodule

// File: tb/tb_bpred_unit.sv
// tb/tb_bpred_unit.sv - directed self-checking bench for bpred_unit
module tb_bpred_unit;
    logic        CLK;
    logic        nRST;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    int errors = 0;
    int checks = 0;
    int exp_br = 0;
    int exp_mis = 0;

    bpred_unit #(.BTB_ENTRIES(8)) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_en         (upd_en),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_pred_taken (upd_pred_taken),
        .br_count       (br_count),
        .mispred_count  (mispred_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic exp_t, input logic [31:0] exp_tgt);
        if_pc = pc;
        #1;
        check({tag, "_taken"}, {31'h0, pred_taken}, {31'h0, exp_t});
        check({tag, "_target"}, pred_target, exp_tgt);
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic pt);
        upd_en = 1'b1;
        upd_pc = pc;
        upd_taken = tk;
        upd_target = tgt;
        upd_pred_taken = pt;
        exp_br++;
        if (pt != tk) exp_mis++;
        @(posedge CLK);
        #1;
        upd_en = 1'b0;
    endtask

    initial begin
        nRST = 1'b0;
        if_pc = 32'h40;
        upd_en = 1'b0;
        upd_pc = 32'h0;
        upd_taken = 1'b0;
        upd_target = 32'h0;
        upd_pred_taken = 1'b0;
        repeat (2) @(posedge CLK);
        look("reset", 32'h40, 1'b0, 32'h0);
        check("reset_br", br_count, 32'h0);
        check("reset_mis", mispred_count, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        look("cold_miss", 32'h40, 1'b0, 32'h0);

        upd(32'h40, 1'b1, 32'h100, 1'b0);
        look("alloc", 32'h40, 1'b1, 32'h100);
        upd(32'h40, 1'b0, 32'h0, 1'b1);
        look("nt1_ctr01", 32'h40, 1'b0, 32'h0);
        upd(32'h40, 1'b0, 32'h0, 1'b0);
        look("nt2_ctr00", 32'h40, 1'b0, 32'h0);
        upd(32'h40, 1'b0, 32'h0, 1'b0);
        look("nt3_sat00", 32'h40, 1'b0, 32'h0);
        upd(32'h40, 1'b1, 32'h100, 1'b0);
        look("t1_ctr01", 32'h40, 1'b0, 32'h0);
        upd(32'h40, 1'b1, 32'h100, 1'b0);
        look("t2_ctr10", 32'h40, 1'b1, 32'h100);
        upd(32'h40, 1'b1, 32'h100, 1'b1);
        upd(32'h40, 1'b1, 32'h100, 1'b1);
        upd(32'h40, 1'b0, 32'h0, 1'b1);
        look("sat11_then_nt", 32'h40, 1'b1, 32'h100);
        upd(32'h40, 1'b1, 32'h100, 1'b1);

        // Conflict at index 0: lookup during the update must still see the old entry.
        if_pc = 32'h40;
        upd_en = 1'b1;
        upd_pc = 32'h60;
        upd_taken = 1'b1;
        upd_target = 32'h200;
        upd_pred_taken = 1'b0;
        exp_br++;
        exp_mis++;
        #1;
        check("same_cycle_taken", {31'h0, pred_taken}, 32'h1);
        check("same_cycle_target", pred_target, 32'h100);
        @(posedge CLK);
        #1;
        upd_en = 1'b0;
        look("evicted", 32'h40, 1'b0, 32'h0);
        look("new_tag", 32'h60, 1'b1, 32'h200);

        upd(32'h80, 1'b0, 32'h0, 1'b0);
        look("miss_nt_noalloc", 32'h80, 1'b0, 32'h0);
        look("miss_nt_keep", 32'h60, 1'b1, 32'h200);
        upd(32'h60, 1'b1, 32'h300, 1'b1);
        look("retarget", 32'h60, 1'b1, 32'h300);
        upd(32'h44, 1'b1, 32'h444, 1'b0);
        look("idx1", 32'h44, 1'b1, 32'h444);
        look("idx0_kept", 32'h60, 1'b1, 32'h300);

        upd_pc = 32'h80;
        upd_taken = 1'b1;
        upd_target = 32'h888;
        upd_pred_taken = 1'b0;
        @(posedge CLK);
        #1;
        look("no_en_noalloc", 32'h80, 1'b0, 32'h0);
        look("no_en_keep", 32'h60, 1'b1, 32'h300);

`ifdef BPRED_STATS_EN
        check("br_count", br_count, exp_br);
        check("mispred_count", mispred_count, exp_mis);
`else
        check("br_count_off", br_count, 32'h0);
        check("mispred_count_off", mispred_count, 32'h0);
`endif

        // Asynchronous reset between edges, with an update held across it.
        if_pc = 32'h60;
        #2;
        nRST = 1'b0;
        upd_en = 1'b1;
        upd_pc = 32'h48;
        upd_taken = 1'b1;
        upd_target = 32'h999;
        #1;
        check("async_taken", {31'h0, pred_taken}, 32'h0);
        check("async_target", pred_target, 32'h0);
        check("async_br", br_count, 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        upd_en = 1'b0;
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        look("post_rst_60", 32'h60, 1'b0, 32'h0);
        look("post_rst_44", 32'h44, 1'b0, 32'h0);
        look("post_rst_48", 32'h48, 1'b0, 32'h0);
        check("post_rst_br", br_count, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
